// File: rtl/booth_pkg.sv
// booth_pkg: shared constants for the radix-2 Booth sequencing controller.
//   - default operand width and iteration-counter width
//   - FSM state encoding (3-bit) and its enum type
package booth_pkg;

  localparam int unsigned N_BITS_DEF = 4;
  localparam int unsigned CNT_W_DEF  = 3;
  localparam int unsigned STATE_W    = 3;

  localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] S_INIT  = 3'd1;
  localparam logic [STATE_W-1:0] S_EVAL  = 3'd2;
  localparam logic [STATE_W-1:0] S_SHIFT = 3'd3;
  localparam logic [STATE_W-1:0] S_FIN   = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = S_IDLE,
    ST_INIT  = S_INIT,
    ST_EVAL  = S_EVAL,
    ST_SHIFT = S_SHIFT,
    ST_FIN   = S_FIN
  } state_e;

endpackage

// File: rtl/booth_if.sv
// booth_if: handshake and control bundle between the Booth controller and
// its datapath / requester.
//   master (controller): in  start, q0, q_m1
//                        out load_m, load_q, clear_a, load_a, sub, shift,
//                            busy, done, iter[CNT_W]
//   slave  (datapath)  : mirror image of master
interface booth_if #(
  parameter int unsigned CNT_W = booth_pkg::CNT_W_DEF
);

  logic             start;
  logic             q0;
  logic             q_m1;
  logic             load_m;
  logic             load_q;
  logic             clear_a;
  logic             load_a;
  logic             sub;
  logic             shift;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] iter;

  modport master (
    input  start, q0, q_m1,
    output load_m, load_q, clear_a, load_a, sub, shift, busy, done, iter
  );

  modport slave (
    output start, q0, q_m1,
    input  load_m, load_q, clear_a, load_a, sub, shift, busy, done, iter
  );

endinterface

// File: rtl/booth_controller_iter_counter.sv
// iter_counter: CNT_W-bit down counter of remaining Booth iterations.
//   clk, reset : clock, asynchronous active-high reset (count -> 0)
//   load       : synchronous load of N_BITS (has priority over dec)
//   dec        : decrement by one; saturates at zero
//   cnt        : current count
//   zero       : count == 0
module iter_counter
  import booth_pkg::*;
#(
  parameter int unsigned N_BITS = N_BITS_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load wins, decrement never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(N_BITS);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/booth_controller.sv
// booth_controller: sequencing FSM for a radix-2 Booth multiplier datapath.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : booth_if.master
//           start          - request a multiply (honoured only in IDLE)
//           q0, q_m1       - Q[0] and Q-1 from the datapath
//           load_m/load_q  - load operands (INIT only)
//           clear_a        - zero A and Q-1 (INIT only)
//           load_a, sub    - A <= A+M (sub=0) or A-M (sub=1), EVAL only
//           shift          - arithmetic right shift of {A,Q,Q-1}
//           busy, done     - in progress / one-cycle completion pulse
//           iter           - remaining iterations (debug)
// Flow: IDLE -> INIT -> (EVAL -> SHIFT) x N_BITS -> FIN -> IDLE.
module booth_controller
  import booth_pkg::*;
#(
  parameter int unsigned N_BITS = N_BITS_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic     clk,
  input  logic     reset,
  booth_if.master  bus
);

  state_e state_q, state_d;

  logic load_m_q, load_m_d;
  logic load_q_q, load_q_d;
  logic clear_a_q, clear_a_d;
  logic shift_q, shift_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  // Add/sub decode must see Q[0]/Q-1 after they settle in EVAL, so it
  // is decoded combinationally from the state register.
  logic load_a_c;
  logic sub_c;

  logic [CNT_W-1:0] iter;
  logic             iter_zero;
  logic             cnt_load;
  logic             cnt_dec;

  assign cnt_load = (state_q == ST_INIT);
  assign cnt_dec  = (state_q == ST_SHIFT);

  iter_counter #(
    .N_BITS (N_BITS),
    .CNT_W  (CNT_W)
  ) u_iter_counter (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .cnt   (iter),
    .zero  (iter_zero)
  );

  // Next state, Booth decode and next values of the registered controls.
  always_comb begin
    state_d   = state_q;
    load_a_c  = 1'b0;
    sub_c     = 1'b0;
    load_m_d  = 1'b0;
    load_q_d  = 1'b0;
    clear_a_d = 1'b0;
    shift_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        state_d = ST_EVAL;
      end
      ST_EVAL: begin
        state_d = ST_SHIFT;
        case ({bus.q0, bus.q_m1})
          2'b10: begin
            load_a_c = 1'b1;
            sub_c    = 1'b1;
          end
          2'b01: begin
            load_a_c = 1'b1;
          end
          default: begin
            load_a_c = 1'b0;
          end
        endcase
      end
      ST_SHIFT: begin
        // Zero check only guards against an inconsistent count.
        if ((iter == CNT_W'(1)) || iter_zero) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_EVAL;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered controls follow the state being entered.
    load_m_d  = (state_d == ST_INIT);
    load_q_d  = (state_d == ST_INIT);
    clear_a_d = (state_d == ST_INIT);
    shift_d   = (state_d == ST_SHIFT);
    busy_d    = (state_d == ST_INIT) || (state_d == ST_EVAL) ||
                (state_d == ST_SHIFT);
    done_d    = (state_d == ST_FIN);
  end

  // State and control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      load_m_q  <= 1'b0;
      load_q_q  <= 1'b0;
      clear_a_q <= 1'b0;
      shift_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      load_m_q  <= load_m_d;
      load_q_q  <= load_q_d;
      clear_a_q <= clear_a_d;
      shift_q   <= shift_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.load_m  = load_m_q;
  assign bus.load_q  = load_q_q;
  assign bus.clear_a = clear_a_q;
  assign bus.load_a  = load_a_c;
  assign bus.sub     = sub_c;
  assign bus.shift   = shift_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.iter    = iter;

endmodule

// File: tb/tb_booth_controller.sv
// tb_booth_controller: directed self-checking bench for booth_controller.
// A behavioural 4-bit Booth datapath (A, Q, M, Q-1) is driven by the
// controller so complete products can be checked against hand values.
module tb_booth_controller;
  import booth_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  booth_if #(.CNT_W(CW)) bus ();

  booth_controller #(.N_BITS(N), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // q0/q_m1 come either from the datapath model or from forced values.
  logic       use_dp = 1'b0;
  logic       f_q0   = 1'b0;
  logic       f_qm1  = 1'b0;
  logic [3:0] m_in   = '0;
  logic [3:0] q_in   = '0;
  logic [4:0] a5     = '0;   // A plus a guard bit holding the true sign
  logic [3:0] m_r    = '0;
  logic [3:0] q_r    = '0;
  logic       qm1_r  = 1'b0;

  assign bus.q0   = use_dp ? q_r[0] : f_q0;
  assign bus.q_m1 = use_dp ? qm1_r  : f_qm1;

  // Datapath model: loads have priority over the shift.
  always @(posedge clk) begin
    if (bus.load_m) m_r <= m_in;
    if (bus.load_q) q_r <= q_in;
    if (bus.clear_a) begin
      a5    <= '0;
      qm1_r <= 1'b0;
    end else if (bus.load_a) begin
      a5 <= bus.sub ? (a5 - {m_r[3], m_r}) : (a5 + {m_r[3], m_r});
    end else if (bus.shift) begin
      a5    <= {a5[4], a5[4:1]};
      q_r   <= {a5[0], q_r[3:1]};
      qm1_r <= q_r[0];
    end
  end

  function automatic logic [7:0] outs();
    return {bus.load_m, bus.load_q, bus.clear_a, bus.load_a,
            bus.sub, bus.shift, bus.busy, bus.done};
  endfunction

  // Exclusivity invariants, every cycle outside reset.
  always @(negedge clk) begin
    if (!reset) begin
      n_checks++;
      if ((bus.load_a && bus.shift) || (bus.sub && !bus.load_a) ||
          (bus.done && bus.busy) ||
          ((bus.load_m || bus.load_q || bus.clear_a) &&
           !(bus.load_m && bus.load_q && bus.clear_a && bus.busy &&
             !bus.shift && !bus.load_a && !bus.done))) begin
        n_fail++;
        $display("FAIL invariant t=%0t: outs{lm,lq,ca,la,sub,sh,busy,done}=%b",
                 $time, outs());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requires IDLE; returns at the sample point of the INIT cycle.
  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (outs() !== 8'h00 || bus.iter !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_hold: outs=%b iter=%0d, want outs=00000000 iter=0", outs(), bus.iter);
    end
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (outs() !== 8'h00 || bus.iter !== 3'd0) begin
        n_fail++;
        $display("FAIL reset_release c=%0d: outs=%b iter=%0d, want 00000000 iter=0", c, outs(), bus.iter);
      end
    end
  endtask

  task automatic test_sequence();
    int shifts = 0;
    int load_a_seen = 0;
    int dones = 0;
    int done_n = 0;
    logic [7:0] exp;
    use_dp = 1'b0;
    f_q0   = 1'b0;
    f_qm1  = 1'b0;
    pulse_start();
    n_checks++;
    if (outs() !== 8'b1110_0010) begin
      n_fail++;
      $display("FAIL seq_init: outs=%b want 11100010", outs());
    end
    for (int n = 2; n <= 11; n++) begin
      tick();
      if (n == 10)                  exp = 8'b0000_0001;
      else if (n == 11)             exp = 8'b0000_0000;
      else if ((n % 2) == 1)        exp = 8'b0000_0110;
      else                          exp = 8'b0000_0010;
      n_checks++;
      if (outs() !== exp) begin
        n_fail++;
        $display("FAIL seq_cycle n=%0d: outs=%b want %b", n, outs(), exp);
      end
      if (bus.shift)  shifts++;
      if (bus.load_a) load_a_seen++;
      if (bus.done) begin
        dones++;
        done_n = n;
      end
      if (n == 2) begin
        n_checks++;
        if (bus.iter !== 3'd4) begin
          n_fail++;
          $display("FAIL seq_iter_load: iter=%0d want 4", bus.iter);
        end
      end
      if (n == 10) begin
        n_checks++;
        if (bus.iter !== 3'd0) begin
          n_fail++;
          $display("FAIL seq_iter_end: iter=%0d want 0", bus.iter);
        end
      end
    end
    n_checks++;
    if (shifts != 4 || load_a_seen != 0 || dones != 1 || done_n != 10) begin
      n_fail++;
      $display("FAIL seq_counts: shifts=%0d load_a=%0d dones=%0d done_cycle=%0d want 4 0 1 10",
               shifts, load_a_seen, dones, done_n);
    end
  endtask

  task automatic test_booth_decode();
    int done_n = 0;
    use_dp = 1'b0;
    f_q0   = 1'b1;
    f_qm1  = 1'b0;
    pulse_start();
    tick();  // EVAL
    n_checks++;
    if (outs() !== 8'b0001_1010) begin
      n_fail++;
      $display("FAIL decode_10: outs=%b want 00011010", outs());
    end
    f_q0 = 1'b0; f_qm1 = 1'b1; #1;
    n_checks++;
    if (bus.load_a !== 1'b1 || bus.sub !== 1'b0) begin
      n_fail++;
      $display("FAIL decode_01: load_a=%b sub=%b want 1 0", bus.load_a, bus.sub);
    end
    f_q0 = 1'b1; f_qm1 = 1'b1; #1;
    n_checks++;
    if (bus.load_a !== 1'b0 || bus.sub !== 1'b0) begin
      n_fail++;
      $display("FAIL decode_11: load_a=%b sub=%b want 0 0", bus.load_a, bus.sub);
    end
    f_q0 = 1'b0; f_qm1 = 1'b0; #1;
    n_checks++;
    if (bus.load_a !== 1'b0 || bus.sub !== 1'b0) begin
      n_fail++;
      $display("FAIL decode_00: load_a=%b sub=%b want 0 0", bus.load_a, bus.sub);
    end
    f_q0 = 1'b1; f_qm1 = 1'b0;
    tick();  // SHIFT: no add/sub regardless of q bits
    n_checks++;
    if (bus.load_a !== 1'b0 || bus.sub !== 1'b0 || bus.shift !== 1'b1) begin
      n_fail++;
      $display("FAIL decode_in_shift: load_a=%b sub=%b shift=%b want 0 0 1",
               bus.load_a, bus.sub, bus.shift);
    end
    for (int n = 4; n <= 20 && done_n == 0; n++) begin
      tick();
      if (bus.done) done_n = n;
    end
    n_checks++;
    if (done_n != 10) begin
      n_fail++;
      $display("FAIL decode_done: done cycle=%0d want 10 (0 = timeout)", done_n);
    end
    tick();
    f_q0 = 1'b0;
  endtask

  task automatic test_datapath(input logic [3:0] m, input logic [3:0] q,
                               input logic [7:0] exp_p);
    int done_n = 0;
    logic [7:0] prod = '0;
    use_dp = 1'b1;
    m_in   = m;
    q_in   = q;
    pulse_start();
    for (int n = 2; n <= 20 && done_n == 0; n++) begin
      tick();
      if (bus.done) begin
        done_n = n;
        prod   = {a5[3:0], q_r};
      end
    end
    n_checks++;
    if (done_n != 10) begin
      n_fail++;
      $display("FAIL dp_latency M=%b Q=%b: done cycle=%0d want 10 (0 = timeout)", m, q, done_n);
    end
    n_checks++;
    if (prod !== exp_p) begin
      n_fail++;
      $display("FAIL dp_product M=%b Q=%b: {A,Q}=%b want %b", m, q, prod, exp_p);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    int pos[3] = '{0, 0, 0};
    use_dp = 1'b0;
    bus.start = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      tick();
      if (bus.done) begin
        if (dones < 3) pos[dones] = c;
        dones++;
      end
    end
    bus.start = 1'b0;
    n_checks++;
    if (dones != 3) begin
      n_fail++;
      $display("FAIL b2b_count: dones=%0d want 3", dones);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (pos[i] != 10 + 11 * i) begin
        n_fail++;
        $display("FAIL b2b_pos[%0d]: done cycle=%0d want %0d", i, pos[i], 10 + 11 * i);
      end
    end
    tick();
  endtask

  task automatic test_start_ignored();
    int dones = 0;
    int inits = 0;
    use_dp = 1'b0;
    pulse_start();
    for (int n = 2; n <= 25; n++) begin
      tick();
      if (bus.done)   dones++;
      if (bus.load_m) inits++;
      bus.start = ((n >= 3) && (n <= 6)) || (n == 9) || (n == 10);
    end
    bus.start = 1'b0;
    n_checks++;
    if (dones != 1 || inits != 0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL start_ignored: dones=%0d inits=%0d busy=%b want 1 0 0", dones, inits, bus.busy);
    end
  endtask

  task automatic test_reset_mid_op();
    use_dp = 1'b1;
    m_in   = 4'b0011;
    q_in   = 4'b1110;
    pulse_start();
    for (int n = 2; n <= 5; n++) tick();
    n_checks++;
    if (bus.shift !== 1'b1 || bus.iter !== 3'd3) begin
      n_fail++;
      $display("FAIL rst_mid_pre: shift=%b iter=%0d want 1 3", bus.shift, bus.iter);
    end
    #3 reset = 1'b1;
    #1;
    n_checks++;
    if (outs() !== 8'h00 || bus.iter !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_mid_async: outs=%b iter=%0d want 00000000 0", outs(), bus.iter);
    end
    tick();
    reset = 1'b0;
    tick();
    n_checks++;
    if (outs() !== 8'h00 || bus.iter !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_mid_after: outs=%b iter=%0d want 00000000 0", outs(), bus.iter);
    end
    test_datapath(4'b0111, 4'b1001, 8'b1100_1111);
  endtask

  initial begin
    bus.start = 1'b0;
    test_reset();
    test_sequence();
    test_booth_decode();
    test_datapath(4'b0011, 4'b1110, 8'b1111_1010);
    test_datapath(4'b0111, 4'b1001, 8'b1100_1111);
    test_datapath(4'b1000, 4'b1000, 8'b0100_0000);
    test_back_to_back();
    test_start_ignored();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
